// File: rtl/mel_window_buffer.sv
// Sliding window of mel-spectrogram frames.
// Frames are written into a circular buffer. Once the buffer is full and
// HOP_FRAMES new frames have arrived since the last readout, a readout
// request streams the whole window out, oldest frame first, with
// coefficient 0 of each frame leading.
//
// Handshakes: a beat transfers on a rising edge where valid && ready are
// both high. A producer holds its data and valid stable until that edge;
// ready may change freely. mel_valid/mel_ready and rd_valid/rd_ready both
// follow this rule.
module mel_window_buffer #(
  parameter int NUM_COEFF  = 40,
  parameter int BIT_WIDTH  = 16,
  parameter int NUM_FRAMES = 256,
  parameter int HOP_FRAMES = 32
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           mel_valid,
  input  logic [NUM_COEFF*BIT_WIDTH-1:0] mel_data,
  output logic                           mel_ready,
  input  logic                           rd_start,
  output logic                           rd_valid,
  input  logic                           rd_ready,
  output logic [BIT_WIDTH-1:0]           rd_data,
  output logic                           rd_last,
  output logic                           window_ready,
  output logic                           busy,
  output logic                           dbg_state
);

  localparam int PTR_W  = (NUM_FRAMES > 1) ? $clog2(NUM_FRAMES) : 1;
  localparam int FILL_W = $clog2(NUM_FRAMES + 1);
  localparam int HOP_W  = $clog2(HOP_FRAMES + 1);
  localparam int COEF_W = (NUM_COEFF > 1) ? $clog2(NUM_COEFF) : 1;

  localparam logic [PTR_W-1:0]  PTR_LAST  = PTR_W'(NUM_FRAMES - 1);
  localparam logic [FILL_W-1:0] FILL_FULL = FILL_W'(NUM_FRAMES);
  localparam logic [HOP_W-1:0]  HOP_FULL  = HOP_W'(HOP_FRAMES);
  localparam logic [COEF_W-1:0] COEF_LAST = COEF_W'(NUM_COEFF - 1);

  typedef enum logic {
    IDLE = 1'b0,
    READ = 1'b1
  } state_t;

  // Packed index NUM_COEFF-1 holds coefficient 0 (the MSBs of mel_data).
  logic [NUM_COEFF-1:0][BIT_WIDTH-1:0] mem [NUM_FRAMES];

  state_t              state;
  logic [PTR_W-1:0]    wr_ptr;
  logic [PTR_W-1:0]    wr_ptr_nxt;
  logic [FILL_W-1:0]   fill_cnt;
  logic [HOP_W-1:0]    hop_cnt;
  logic [PTR_W-1:0]    rd_frame;   // buffer slot being read
  logic [PTR_W-1:0]    rd_fcnt;    // frames already started in this readout
  logic [COEF_W-1:0]   rd_cidx;    // packed index, counts down = coeff 0 first
  logic                accept;
  logic                beat_last;

  assign mel_ready    = (state == IDLE);
  assign busy         = (state == READ);
  assign dbg_state    = (state == READ);
  assign window_ready = (state == IDLE) && (fill_cnt == FILL_FULL) &&
                        (hop_cnt == HOP_FULL);
  assign accept       = mel_valid && mel_ready;
  assign beat_last    = (rd_fcnt == PTR_LAST) && (rd_cidx == '0);

  // Write pointer after this cycle's write, so a coincident start sees the new frame.
  always_comb begin
    wr_ptr_nxt = wr_ptr;
    if (accept) begin
      wr_ptr_nxt = (wr_ptr == PTR_LAST) ? '0 : wr_ptr + 1'b1;
    end
  end

  // Frame storage; contents are not reset, only the fill count is.
  always_ff @(posedge clk) begin
    if (accept) begin
      mem[wr_ptr] <= mel_data;
    end
  end

  // Control FSM, write counters and registered read output stage.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      wr_ptr   <= '0;
      fill_cnt <= '0;
      hop_cnt  <= '0;
      rd_frame <= '0;
      rd_fcnt  <= '0;
      rd_cidx  <= '0;
      rd_valid <= 1'b0;
      rd_last  <= 1'b0;
      rd_data  <= '0;
    end else begin
      if (accept) begin
        wr_ptr <= wr_ptr_nxt;
        if (fill_cnt != FILL_FULL) fill_cnt <= fill_cnt + 1'b1;
        if (hop_cnt != HOP_FULL)   hop_cnt  <= hop_cnt + 1'b1;
      end
      case (state)
        IDLE: begin
          if (rd_start && window_ready) begin
            state    <= READ;
            rd_frame <= wr_ptr_nxt;  // oldest frame once any coincident write lands
            rd_fcnt  <= '0;
            rd_cidx  <= COEF_LAST;
          end
        end
        READ: begin
          if (rd_valid && rd_ready && rd_last) begin
            state    <= IDLE;
            rd_valid <= 1'b0;
            rd_last  <= 1'b0;
            hop_cnt  <= '0;
          end else if (!rd_valid || rd_ready) begin
            rd_valid <= 1'b1;
            rd_data  <= mem[rd_frame][rd_cidx];
            rd_last  <= beat_last;
            if (rd_cidx == '0) begin
              rd_cidx <= COEF_LAST;
              if (!beat_last) begin
                rd_fcnt  <= rd_fcnt + 1'b1;
                rd_frame <= (rd_frame == PTR_LAST) ? '0 : rd_frame + 1'b1;
              end
            end else begin
              rd_cidx <= rd_cidx - 1'b1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
